// File: rtl/fpadd_issue.sv
// fpadd_issue: credit-gated issue/collect wrapper for the pipelined fpadd core with an in-order result FIFO.
// Optional FPADD_ISSUE_STATS_EN adds pop counter and sticky exception flags.
module fpadd_issue #(
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_a,
    input  logic [DWIDTH-1:0] in_b,
    output logic              fp_valid,
    output logic [DWIDTH-1:0] fp_a,
    output logic [DWIDTH-1:0] fp_b,
    input  logic              fp_done,
    input  logic [DWIDTH-1:0] fp_sum,
    input  logic [2:0]        fp_fex,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_sum,
    output logic [2:0]        out_fex,
    output logic              idle,
    output logic              err
`ifdef FPADD_ISSUE_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       op_count,
    output logic [2:0]        fex_sticky
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0]     inflight_q, inflight_d, count_q, count_d;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [DWIDTH+2:0] mem_q [DEPTH];
    logic              err_q, err_d;
    logic [CW:0]       used;
    logic              done_ok, full, push, pop;

    // Credit covers both in-flight ops and buffered results, so fpadd never outruns the FIFO.
    always_comb begin
        used       = {1'b0, inflight_q} + {1'b0, count_q};
        in_ready   = rst_n & (used < (CW+1)'(DEPTH));
        fp_valid   = in_valid & in_ready;
        done_ok    = fp_done & (inflight_q != '0);
        full       = count_q == CW'(DEPTH);
        push       = done_ok & ~full;
        out_valid  = count_q != '0;
        pop        = out_valid & out_ready;
        inflight_d = inflight_q + CW'(fp_valid) - CW'(done_ok);
        count_d    = count_q + CW'(push) - CW'(pop);
        err_d      = err_q | (fp_done & (~done_ok | full));
    end

    assign fp_a    = in_a;
    assign fp_b    = in_b;
    assign out_sum = out_valid ? mem_q[rptr_q][DWIDTH-1:0] : '0;
    assign out_fex = out_valid ? mem_q[rptr_q][DWIDTH+2:DWIDTH] : '0;
    assign idle    = (inflight_q == '0) & (count_q == '0);
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_q + PW'(push);
            rptr_q     <= rptr_q + PW'(pop);
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {fp_fex, fp_sum};
    end

`ifdef FPADD_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count   <= '0;
            fex_sticky <= '0;
        end else if (stats_clr) begin
            op_count   <= '0;
            fex_sticky <= '0;
        end else if (pop) begin
            op_count   <= op_count + 16'd1;
            fex_sticky <= fex_sticky | out_fex;
        end
    end
`endif
endmodule

// File: tb/tb_fpadd_issue.sv
// tb_fpadd_issue: self-checking bench for fpadd_issue with a fixed-latency stand-in fpadd core.
module tb_fpadd_issue;
    localparam int DW = 32, DEPTH = 8, LAT = 5;

    logic          clk = 0, rst_n = 0;
    logic          in_valid, in_ready, fp_valid, fp_done, out_valid, out_ready, idle, err;
    logic [DW-1:0] in_a, in_b, fp_a, fp_b, fp_sum, out_sum;
    logic [2:0]    fp_fex, out_fex;
`ifdef FPADD_ISSUE_STATS_EN
    logic          stats_clr = 0;
    logic [15:0]   op_count;
    logic [2:0]    fex_sticky;
`endif

    fpadd_issue #(.DWIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .fp_valid(fp_valid), .fp_a(fp_a), .fp_b(fp_b),
        .fp_done(fp_done), .fp_sum(fp_sum), .fp_fex(fp_fex),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_fex(out_fex),
        .idle(idle), .err(err)
`ifdef FPADD_ISSUE_STATS_EN
        , .stats_clr(stats_clr), .op_count(op_count), .fex_sticky(fex_sticky)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in core result: the 1.0+2.0 pair yields 3.0, anything else a+b; flags from a[2:0].
    function automatic logic [34:0] core(input logic [31:0] a, input logic [31:0] b);
        return {a[2:0], (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b};
    endfunction

    logic        pv [LAT];
    logic [34:0] pd [LAT];
    logic        inj_done = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin pv[i] <= 0; pd[i] <= '0; end
        end else begin
            pv[0] <= fp_valid;
            pd[0] <= core(fp_a, fp_b);
            for (int i = 1; i < LAT; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
        end
    end
    assign fp_done = pv[LAT-1] | inj_done;
    assign fp_sum  = pd[LAT-1][31:0];
    assign fp_fex  = pd[LAT-1][34:32];

    // Reference: queue of accepted ops in issue order, each visible LAT+1 cycles after issue.
    typedef struct { logic [34:0] d; int rc; } res_t;
    res_t q[$];
    int   cyc = 0, fpv_cnt = 0, pops = 0, ov_seen = 0;
    logic exp_err = 0;

    always @(posedge clk) cyc++;
    always @(negedge rst_n) begin q.delete(); exp_err = 0; end

    always @(negedge clk) if (rst_n) begin
        bit exp_ov, acc;
        exp_ov = q.size() > 0 && q[0].rc <= cyc;
        acc    = in_valid && q.size() < DEPTH;
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("fp_valid", fp_valid, acc);
        if (fp_valid) begin chk("fp_a", fp_a, in_a); chk("fp_b", fp_b, in_b); end
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_sum", out_sum, q[0].d[31:0]);
            chk("out_fex", out_fex, q[0].d[34:32]);
        end
        chk("idle", idle, q.size() == 0);
        chk("err", err, exp_err);
        if (inj_done) exp_err = 1;
        fpv_cnt += int'(fp_valid);
        ov_seen += int'(out_valid);
        if (exp_ov && out_ready) begin void'(q.pop_front()); pops++; end
        if (acc) q.push_back('{core(in_a, in_b), cyc + LAT + 1});
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!idle && n < 300) begin step(); n++; end
        chk(name, idle, 1);
    endtask

    typedef struct { logic [31:0] a, b, s; logic [2:0] f; } vec_t;
    vec_t tbl[5];

    initial begin #400000; $display("FAIL timeout"); $fatal(1); end

    initial begin
        int n, p0, idx, lowc;
        tbl[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 3'b000};
        tbl[1] = '{32'h5, 32'h3, 32'h8, 3'b101};
        tbl[2] = '{32'hC, 32'h1, 32'hD, 3'b100};
        tbl[3] = '{32'h1, 32'h10, 32'h11, 3'b001};
        tbl[4] = '{32'hFFFFFFFF, 32'h1, 32'h0, 3'b111};
        in_valid = 1; in_a = 32'h1; in_b = 0; out_ready = 0;
        #12;
        chk("rst in_ready", in_ready, 0);
        chk("rst fp_valid", fp_valid, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_sum", out_sum, 0);
        chk("rst out_fex", out_fex, 0);
        chk("rst idle", idle, 1);
        chk("rst err", err, 0);
        in_valid = 0;
        step(); rst_n = 1; step();

        out_ready = 1;
        foreach (tbl[i]) begin
            p0 = fpv_cnt;
            in_valid = 1; in_a = tbl[i].a; in_b = tbl[i].b;
            step(); in_valid = 0; n = 1;
            while (!out_valid && n < 20) begin step(); n++; end
            chk("t1 latency", n, LAT + 1);
            chk("t1 sum", out_sum, tbl[i].s);
            chk("t1 fex", out_fex, tbl[i].f);
            step();
            chk("t1 pulses", fpv_cnt - p0, 1);
            chk("t1 idle", idle, 1);
        end

        out_ready = 0; idx = 0;
        repeat (20) begin
            in_valid = idx < 10; in_a = 32'(idx + 100); in_b = 32'(idx); #1;
            if (in_valid && in_ready) idx++;
            step();
        end
        chk("t2 issued", idx, 8);
        chk("t2 in_ready", in_ready, 0);
        out_ready = 1; p0 = pops; n = 0;
        while ((pops - p0 < 10 || idx < 10) && n < 100) begin
            in_valid = idx < 10; in_a = 32'(idx + 100); in_b = 32'(idx); #1;
            if (in_valid && in_ready) idx++;
            step(); n++;
        end
        in_valid = 0;
        chk("t2 delivered", pops - p0, 10);
        chk("t2 err", err, 0);
        wait_idle("t2 idle");

        p0 = fpv_cnt; lowc = 0;
        repeat (40) begin
            in_valid = 1; in_a = $urandom; in_b = $urandom; #1;
            lowc += int'(!in_ready);
            step();
        end
        in_valid = 0;
        chk("t3 stalls", lowc, 0);
        chk("t3 issued", fpv_cnt - p0, 40);
        wait_idle("t3 idle");

        repeat (300) begin
            in_valid = ($urandom % 4) != 0; in_a = $urandom; in_b = $urandom;
            out_ready = ($urandom % 3) != 0;
            step();
        end
        in_valid = 0; out_ready = 1;
        wait_idle("t4 idle");

        repeat (3) begin in_valid = 1; in_a = $urandom; in_b = $urandom; step(); end
        in_valid = 0; step();
        chk("t5 busy", idle, 0);
        #3 rst_n = 0; in_valid = 1; #1;
        chk("t5 in_ready", in_ready, 0);
        chk("t5 fp_valid", fp_valid, 0);
        chk("t5 out_valid", out_valid, 0);
        chk("t5 idle", idle, 1);
        in_valid = 0;
        #10 rst_n = 1;
        p0 = ov_seen;
        repeat (15) step();
        chk("t5 no out", ov_seen - p0, 0);
        chk("t5 idle after", idle, 1);

        inj_done = 1; step(); inj_done = 0;
        chk("t6 err set", err, 1);
        in_valid = 1; in_a = 32'h7; in_b = 32'h1; step(); in_valid = 0;
        wait_idle("t6 idle");
        chk("t6 err sticky", err, 1);
`ifdef FPADD_ISSUE_STATS_EN
        stats_clr = 1; step(); stats_clr = 0;
        in_valid = 1; in_a = 32'h4; in_b = 0; step();
        in_a = 32'h1; step(); in_valid = 0;
        wait_idle("t6s idle");
        chk("t6s op_count", op_count, 2);
        chk("t6s fex_sticky", fex_sticky, 3'b101);
        stats_clr = 1; step(); stats_clr = 0;
        chk("t6s clr count", op_count, 0);
        chk("t6s clr fex", fex_sticky, 0);
`endif
        #3 rst_n = 0; #1;
        chk("t6 err cleared", err, 0);
        step(); rst_n = 1; step();
        chk("final idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
